// File: rtl/keypad_pkg.sv
// Shared key-id encoding, output FSM states and key-id helpers for the keypad encoder.
package keypad_pkg;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_GAP} state_e;

  // Lock-bus code: digit d -> d+1, anything else -> 0.
  function automatic logic [3:0] key_code(input logic [3:0] id);
    return (id <= 4'd9) ? id + 4'd1 : 4'd0;
  endfunction

  // Key id at (row, col); bottom row is *, 0, #.
  function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
    if (row != 2'd3) return {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    case (col)
      2'd0:    return KEY_STAR;
      2'd1:    return 4'd0;
      default: return KEY_HASH;
    endcase
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// Accepts a per-scan candidate once it has repeated for DEBOUNCE consecutive scans.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       scan_end,
  input  logic [3:0] cand,
  output logic [3:0] acc_key,
  output logic       acc_stb
);
  localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE - 1);

  logic [3:0] prev_q, prev_d;
  logic [3:0] stable_q, stable_d;

  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    if (scan_end) begin
      if (cand == prev_q) begin
        stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 4'd1;
      end else begin
        prev_d   = cand;
        stable_d = '0;
      end
    end
  end

  // Fires on every scan end while saturated, so a held key keeps being re-accepted.
  assign acc_stb = scan_end && (stable_d == STABLE_MAX);
  assign acc_key = cand;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prev_q   <= KEY_NONE;
      stable_q <= '0;
    end else begin
      prev_q   <= prev_d;
      stable_q <= stable_d;
    end
  end
endmodule

// File: rtl/keypad_encoder.sv
// 3x4 keypad scanner with debounce and a display FSM that forces a one-scan blank between keys.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] rows,
  output logic [2:0] cols,
  output logic [3:0] keyCode,
  output logic       starKey,
  output logic       hashKey
);
  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
  localparam logic [9:0] GAP_LAST = 10'(3 * SCAN_DIV - 1);

  logic [7:0] div_q, div_d;
  logic [1:0] col_q, col_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] key_q, key_d;
  logic       last, scan_end;
  logic [3:0] cand, acc_key, gap_key;
  logic       acc_stb;

  state_e     state_q;
  logic [3:0] held_q, pend_q;
  logic [9:0] gap_q;

  always_comb begin
    last     = (div_q == DIV_LAST);
    scan_end = last && (col_q == 2'd2);
    div_d    = last ? 8'd0 : div_q + 8'd1;
    col_d    = col_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    if (last) begin
      col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
      // Column 0 starts a fresh scan; count saturates at 2 (= "two or more").
      cnt_d = (col_q == 2'd0) ? 2'd0 : cnt_q;
      key_d = (col_q == 2'd0) ? KEY_NONE : key_q;
      for (int r = 0; r < 4; r++) begin
        if (!rows[r]) begin
          if (cnt_d != 2'd2) cnt_d = cnt_d + 2'd1;
          key_d = key_at(2'(r), col_q);
        end
      end
    end
    cand    = (cnt_d == 2'd1) ? key_d : KEY_NONE;
    gap_key = (acc_stb && acc_key != KEY_NONE) ? acc_key : pend_q;
  end

  assign cols = ~(3'b001 << col_q);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
      key_q <= KEY_NONE;
    end else begin
      div_q <= div_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
      key_q <= key_d;
    end
  end

  keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk     (clk),
    .resetN  (resetN),
    .scan_end(scan_end),
    .cand    (cand),
    .acc_key (acc_key),
    .acc_stb (acc_stb)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      held_q  <= KEY_NONE;
      pend_q  <= KEY_NONE;
      gap_q   <= '0;
      keyCode <= '0;
      starKey <= 1'b0;
      hashKey <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc_stb && acc_key != KEY_NONE) begin
            state_q <= ST_HELD;
            held_q  <= acc_key;
            keyCode <= key_code(acc_key);
            starKey <= (acc_key == KEY_STAR);
            hashKey <= (acc_key == KEY_HASH);
          end
        end
        ST_HELD: begin
          if (acc_stb && acc_key != held_q) begin
            state_q <= (acc_key == KEY_NONE) ? ST_IDLE : ST_GAP;
            pend_q  <= acc_key;
            gap_q   <= '0;
            keyCode <= '0;
            starKey <= 1'b0;
            hashKey <= 1'b0;
          end
        end
        ST_GAP: begin
          if (acc_stb && acc_key == KEY_NONE) begin
            state_q <= ST_IDLE;
          end else if (gap_q == GAP_LAST) begin
            state_q <= ST_HELD;
            held_q  <= gap_key;
            keyCode <= key_code(gap_key);
            starKey <= (gap_key == KEY_STAR);
            hashKey <= (gap_key == KEY_HASH);
          end else begin
            gap_q  <= gap_q + 10'd1;
            pend_q <= gap_key;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          keyCode <= '0;
          starKey <= 1'b0;
          hashKey <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_encoder.sv
// Scan-aligned key stimulus; a per-scan reference model predicts every output change and its cycle.
module tb_keypad_encoder;
  localparam int SCAN = 12;
  localparam int NONE = 15;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [3:0] rows;
  logic [2:0] cols;
  logic [3:0] keyCode;
  logic       starKey, hashKey;
  logic [11:0] pressed = '0;

  typedef struct { logic [5:0] val; int cyc; } exp_t;
  exp_t sb[$];
  int   hist[$];
  int   disp = NONE;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE(4)) dut (
    .clk(clk), .resetN(resetN), .rows(rows), .cols(cols),
    .keyCode(keyCode), .starKey(starKey), .hashKey(hashKey)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int kid(int r, int c);
    if (r < 3) return r * 3 + c + 1;
    return (c == 0) ? 10 : (c == 1) ? 0 : 11;
  endfunction

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!cols[c] && pressed[kid(r, c)]) rows[r] = 1'b0;
  end

  function automatic logic [5:0] outv(int k);
    logic [3:0] code;
    code = 4'(k + 1);
    if (k <= 9) return {code, 2'b00};
    if (k == 10) return 6'b000010;
    if (k == 11) return 6'b000001;
    return 6'b0;
  endfunction

  function automatic int cand_of(logic [11:0] m);
    if ($countones(m) != 1) return NONE;
    for (int i = 0; i < 12; i++) if (m[i]) return i;
    return NONE;
  endfunction

  // Accept after four identical scans; a key-to-key change blanks for one scan.
  task automatic model_scan(int c);
    hist.push_back(c);
    if (hist.size() > 4) void'(hist.pop_front());
    if (hist.size() == 4 && hist[0] == c && hist[1] == c && hist[2] == c && c != disp) begin
      if (c == NONE) sb.push_back('{6'b0, cyc});
      else if (disp == NONE) sb.push_back('{outv(c), cyc});
      else begin
        sb.push_back('{6'b0, cyc});
        sb.push_back('{outv(c), cyc + SCAN});
      end
      disp = c;
    end
  endtask

  task automatic run_scan(logic [11:0] m);
    pressed = m;
    repeat (SCAN) @(posedge clk);
    @(negedge clk);
    model_scan(cand_of(m));
  endtask

  task automatic hold(logic [11:0] m, int n);
    for (int i = 0; i < n; i++) run_scan(m);
  endtask

  task automatic do_reset(int ncyc);
    @(negedge clk);
    #3 resetN = 1'b0;
    #1;
    n_chk++;
    if (cols !== 3'b110 || {keyCode, starKey, hashKey} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_state cols=%b out=%b required cols=110 out=000000", cols, {keyCode, starKey, hashKey});
    end
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    sb.delete();
    hist.delete();
    disp = NONE;
    resetN = 1'b1;
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each output change.
  initial begin
    logic [5:0] prev, cur;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      #1;
      cur = {keyCode, starKey, hashKey};
      if (resetN) begin
        n_chk++;
        if ($countones({keyCode != 4'd0, starKey, hashKey}) > 1 || $countones(~cols) != 1 || keyCode > 4'd10) begin
          n_fail++;
          $display("FAIL invariant cyc=%0d cols=%b out=%b required one-hot cols and one active output", cyc, cols, cur);
        end
        if (cur != prev) begin
          n_chk++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change cyc=%0d got %b required no change", cyc, cur);
          end else begin
            e = sb.pop_front();
            if (e.val != cur || e.cyc != cyc) begin
              n_fail++;
              $display("FAIL output_change got %b at cyc %0d required %b at cyc %0d", cur, cyc, e.val, e.cyc);
            end
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    logic [11:0] m;
    int a, b, t;
    do_reset(3);
    hold(12'h020, 6);  hold(12'h000, 6);                    // 5 press / release
    hold(12'h001, 6);  hold(12'h400, 6);  hold(12'h000, 5); // 0, then * with gap
    hold(12'h800, 6);  hold(12'h000, 5);                    // #
    for (int i = 0; i < 3; i++) begin run_scan(12'h080); run_scan(12'h000); end
    hold(12'h080, 6);  hold(12'h000, 5);                    // toggled 7 then held
    hold(12'h00A, 6);  hold(12'h000, 5);                    // 1 and 3 together
    hold(12'h004, 6);  run_scan(12'h104); hold(12'h100, 6); hold(12'h000, 5); // roll 2 -> 8
    hold(12'h010, 6);
    pressed = 12'h010;
    do_reset(3);                                            // reset while 4 held
    hold(12'h010, 6);  hold(12'h000, 5);
    for (int s = 0; s < 40; s++) begin
      t = $urandom_range(0, 9);
      a = $urandom_range(0, 11);
      b = (a + 1 + $urandom_range(0, 10)) % 12;
      m = '0;
      if (t >= 3) m[a] = 1'b1;
      else if (t == 2) begin m[a] = 1'b1; m[b] = 1'b1; end
      hold(m, $urandom_range(1, 6));
    end
    hold(12'h000, 6);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
